alu_seq_ctrl: RTL and testbench

Initiator/driver side of the 8-op 4-bit ALU interface.
- Accepts ALU commands (opcode, a, b) over a valid/ready handshake.
- Drives them onto the registered ALU operand/opcode port and waits SETTLE_CYCLES.
- Captures the 8-bit result and returns it, tagged with its opcode, through a small response FIFO with valid/ready.
- Sits between a command source (test sequencer or CPU-side register block) and a combinational ALU instance.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_rsp_fifo.sv | 56 +++++
 rtl/alu_seq_ctrl.sv | 117 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and golden ALU model for alu_seq_ctrl
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Operands are zero-extended first so sub/not/xnor produce full 8-bit results.
    function automatic logic [7:0] golden_rslt(input logic [2:0] op,
                                               input logic [3:0] a,
                                               input logic [3:0] b);
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] r;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea - eb;
            OP_MUL:  r = ea * eb;
            OP_AND:  r = ea & eb;
            OP_OR:   r = ea | eb;
            OP_NOT:  r = ~ea;
            OP_XOR:  r = ea ^ eb;
            default: r = ~(ea ^ eb);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_rsp_fifo.sv
// rtl/alu_seq_rsp_fifo.sv - circular response FIFO of {opcode, result} entries
module alu_seq_rsp_fifo #(
    parameter int RSP_DEPTH = 4,
    parameter int WIDTH     = 11,
    localparam int PW       = $clog2(RSP_DEPTH),
    localparam int CW       = $clog2(RSP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU command sequencer; optional result checker under ALU_SEQ_CHECK_EN
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [7:0]  alu_rslt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [2:0]  rsp_opcode,
    output logic [15:0] op_count,
    output logic        chk_err
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [3:0]    CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_e       state_q;
    logic [2:0]   alu_opcode_q;
    logic [3:0]   alu_a_q;
    logic [3:0]   alu_b_q;
    logic [3:0]   cnt_q;
    logic [15:0]  op_count_q;
    logic         capture;
    logic         fifo_empty;
    logic         fifo_full;
    logic [CW-1:0] fifo_count;
    logic [10:0]  fifo_head;

    assign cmd_ready  = (state_q == ST_IDLE) && (fifo_count < DEPTH_C);
    assign capture    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign op_count   = op_count_q;
    assign rsp_valid  = !fifo_empty;
    assign rsp_opcode = fifo_head[10:8];
    assign rsp_data   = fifo_head[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            cnt_q        <= '0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_opcode_q <= cmd_opcode;
                        alu_a_q      <= cmd_a;
                        alu_b_q      <= cmd_b;
                        cnt_q        <= CNT_INIT;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        op_count_q <= op_count_q + 16'd1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Accept is gated on free space, so the full guard on push never drops a result.
    alu_seq_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH),
        .WIDTH     (11)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (capture && !fifo_full),
        .push_data_i ({alu_opcode_q, alu_rslt}),
        .pop_i       (rsp_ready),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

`ifdef ALU_SEQ_CHECK_EN
    logic chk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (capture && (alu_rslt != golden_rslt(alu_opcode_q, alu_a_q, alu_b_q))) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [3:0]  cmd_a;
    logic [3:0]  cmd_b;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [7:0]  alu_rslt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_opcode;
    logic [15:0] op_count;
    logic        chk_err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    alu_seq_ctrl #(
        .SETTLE_CYCLES (1),
        .RSP_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_rslt   (alu_rslt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_opcode (rsp_opcode),
        .op_count   (op_count),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; and(C,A) is deliberately broken to exercise the checker.
    always_comb begin
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'h0, alu_a};
        eb = {4'h0, alu_b};
        case (alu_opcode)
            3'd0:    alu_rslt = ea + eb;
            3'd1:    alu_rslt = ea - eb;
            3'd2:    alu_rslt = ea * eb;
            3'd3:    alu_rslt = (alu_a == 4'hC && alu_b == 4'hA) ? 8'h00 : (ea & eb);
            3'd4:    alu_rslt = ea | eb;
            3'd5:    alu_rslt = ~ea;
            3'd6:    alu_rslt = ea ^ eb;
            default: alu_rslt = ~(ea ^ eb);
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check_eq("issue_ready_seen", 32'(n < 50), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] data, input logic [2:0] op);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(data));
        check_eq({tag, "_op"}, 32'(rsp_opcode), 32'(op));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    logic [2:0] t_op  [0:4];
    logic [3:0] t_a   [0:4];
    logic [3:0] t_b   [0:4];
    int         acc_cyc [0:4];
    logic [7:0] r_data [0:2];
    logic [2:0] r_op   [0:2];
    int         nacc;
    int         nrsp;
    logic       acc;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
        check_eq("rst_op_count", 32'(op_count), 32'd0);
        check_eq("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        check_eq("rst_chk_err", 32'(chk_err), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Single add 9+8
        issue(3'd0, 4'h9, 4'h8);
        check_eq("add_alu_a", 32'(alu_a), 32'h9);
        check_eq("add_alu_b", 32'(alu_b), 32'h8);
        check_eq("add_wait_ready", 32'(cmd_ready), 32'd0);
        check_eq("add_not_yet_valid", 32'(rsp_valid), 32'd0);
        step();
        check_eq("add_op_count", 32'(op_count), 32'd1);
        check_eq("add_ready_again", 32'(cmd_ready), 32'd1);
        check_eq("add_alu_hold", 32'(alu_a), 32'h9);
        pop_expect("add", 8'h11, 3'd0);

        // Back-to-back sub, not, mul with valid held high
        t_op[0] = 3'd1; t_a[0] = 4'h3; t_b[0] = 4'h5;
        t_op[1] = 3'd5; t_a[1] = 4'h3; t_b[1] = 4'h0;
        t_op[2] = 3'd2; t_a[2] = 4'hF; t_b[2] = 4'hF;
        cmd_opcode = t_op[0]; cmd_a = t_a[0]; cmd_b = t_b[0];
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        nacc = 0;
        nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            acc = cmd_valid && cmd_ready;
            if (rsp_valid && nrsp < 3) begin
                r_data[nrsp] = rsp_data;
                r_op[nrsp]   = rsp_opcode;
                nrsp++;
            end
            step();
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                if (nacc < 3) begin
                    cmd_opcode = t_op[nacc]; cmd_a = t_a[nacc]; cmd_b = t_b[nacc];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        rsp_ready = 1'b0;
        check_eq("b2b_accepts", 32'(nacc), 32'd3);
        check_eq("b2b_responses", 32'(nrsp), 32'd3);
        if (nacc == 3) begin
            check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
            check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
        end
        if (nrsp == 3) begin
            check_eq("b2b_sub", 32'({r_op[0], r_data[0]}), 32'({3'd1, 8'hFE}));
            check_eq("b2b_not", 32'({r_op[1], r_data[1]}), 32'({3'd5, 8'hFC}));
            check_eq("b2b_mul", 32'({r_op[2], r_data[2]}), 32'({3'd2, 8'hE1}));
        end
        check_eq("b2b_op_count", 32'(op_count), 32'd4);

        // Back-pressure: five commands into a four-entry FIFO
        t_op[0] = 3'd0; t_a[0] = 4'h1; t_b[0] = 4'h1;
        t_op[1] = 3'd0; t_a[1] = 4'h1; t_b[1] = 4'h2;
        t_op[2] = 3'd3; t_a[2] = 4'hF; t_b[2] = 4'h5;
        t_op[3] = 3'd4; t_a[3] = 4'h8; t_b[3] = 4'h1;
        t_op[4] = 3'd6; t_a[4] = 4'hF; t_b[4] = 4'h0;
        cmd_opcode = t_op[0]; cmd_a = t_a[0]; cmd_b = t_b[0];
        cmd_valid = 1'b1;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                nacc++;
                if (nacc < 5) begin
                    cmd_opcode = t_op[nacc]; cmd_a = t_a[nacc]; cmd_b = t_b[nacc];
                end
            end
        end
        check_eq("full_accepts", 32'(nacc), 32'd4);
        check_eq("full_ready_low", 32'(cmd_ready), 32'd0);
        check_eq("full_op_count", 32'(op_count), 32'd8);
        pop_expect("full_head", 8'h02, 3'd0);
        check_eq("full_ready_after_pop", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check_eq("fifth_in_wait", 32'(cmd_ready), 32'd0);
        check_eq("fifth_alu_a", 32'(alu_a), 32'hF);
        pop_expect("full_e1", 8'h03, 3'd0);
        pop_expect("full_e2", 8'h05, 3'd3);
        pop_expect("full_e3", 8'h09, 3'd4);
        pop_expect("full_e4", 8'h0F, 3'd6);
        check_eq("full_drained", 32'(rsp_valid), 32'd0);
        check_eq("full_op_count_end", 32'(op_count), 32'd9);

        // Simultaneous push and pop with two entries queued
        issue(3'd0, 4'h1, 4'h0);
        issue(3'd0, 4'h2, 4'h0);
        issue(3'd0, 4'h3, 4'h0);
        check_eq("pp_head_before", 32'(rsp_data), 32'h01);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("pp_op_count", 32'(op_count), 32'd12);
        pop_expect("pp_e1", 8'h02, 3'd0);
        pop_expect("pp_e2", 8'h03, 3'd0);
        check_eq("pp_empty", 32'(rsp_valid), 32'd0);

        // Reset while an xor is in flight
        issue(3'd6, 4'hA, 4'h5);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_count", 32'(op_count), 32'd0);
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_rst_count", 32'(op_count), 32'd0);

        // Faulty and(C,A) result, then a correct op
        check_eq("chk_before", 32'(chk_err), 32'd0);
        issue(3'd3, 4'hC, 4'hA);
        step();
        check_eq("chk_fault", 32'(chk_err), 32'(EXP_CHK));
        pop_expect("and_fault", 8'h00, 3'd3);
        issue(3'd0, 4'h2, 4'h3);
        step();
        pop_expect("after_fault", 8'h05, 3'd0);
        check_eq("chk_sticky", 32'(chk_err), 32'(EXP_CHK));
        check_eq("chk_op_count", 32'(op_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
